// File: rtl/multi_shape_processor.sv
// Multi-channel shape control: validated host commands are queued, executed over
// OP_CYCLES cycles, and then committed to per-channel control registers.
//
// state  | meaning
// S_IDLE | no command in flight; pops the FIFO head when one is available
// S_EXEC | command in flight; commits when the cycle counter reaches zero
module multi_shape_processor #(
    parameter int NUM_CHANNELS = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int OP_CYCLES    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        write,
    input  logic [31:0] write_data,
    input  logic        read,
    input  logic [2:0]  read_channel,
    output logic [31:0] read_data,
    output logic        error,
    output logic        busy
);

    localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = (OP_CYCLES > 1) ? $clog2(OP_CYCLES) : 1;
    localparam logic [3:0]       NUM_CH_L = 4'(NUM_CHANNELS);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(OP_CYCLES - 1);

    typedef struct packed {
        logic [2:0] channel;
        logic [1:0] shape;
        logic [4:0] op;
    } cmd_t;

    typedef enum logic {S_IDLE, S_EXEC} state_t;

    state_t state_q, state_d;

    logic [2:0] wr_channel;
    logic [1:0] wr_shape;
    logic [4:0] wr_op;
    logic       shape_ok, op_ok, class_ok, chan_ok, fifo_full, legal;
    logic       push, pop, commit;
    logic       unused_bits;

    cmd_t             fifo_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] slot_valid;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level;

    cmd_t             exec_cmd;
    logic [CNT_W-1:0] cycle_cnt;

    logic [1:0] chan_shape [NUM_CHANNELS];
    logic [4:0] chan_op    [NUM_CHANNELS];
    logic [7:0] chan_count [NUM_CHANNELS];

    logic [CH_W-1:0] ex_idx, rd_idx;
    logic            read_in_range, commit_hit, pending;
    logic [1:0]      view_shape;
    logic [4:0]      view_op;
    logic [7:0]      view_count;

    assign wr_channel  = write_data[26:24];
    assign wr_shape    = write_data[17:16];
    assign wr_op       = write_data[4:0];
    assign unused_bits = ^{write_data[31:27], write_data[23:18], write_data[15:5]};

    // Command legality
    assign shape_ok  = (wr_shape == 2'b01) || (wr_shape == 2'b10);
    assign class_ok  = (wr_op[4:3] == 2'b00) || (wr_op[4:3] == wr_shape);
    assign chan_ok   = ({1'b0, wr_channel} < NUM_CH_L);
    assign fifo_full = (level == FULL_LVL);

    always_comb begin
        op_ok = 1'b0;
        case (wr_op[4:3])
            2'b00:   op_ok = (wr_op[2:0] <= 3'd1);
            2'b01:   op_ok = (wr_op[2:0] == 3'd0);
            2'b10:   op_ok = (wr_op[2:0] <= 3'd1);
            default: op_ok = 1'b0;
        endcase
    end

    assign legal = shape_ok && op_ok && class_ok && chan_ok && !fifo_full;
    assign push  = write && legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error <= 1'b0;
        end else begin
            error <= write && !legal;
        end
    end

    // Command FIFO; a pop never makes room for a push in the same cycle
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{channel: wr_channel, shape: wr_shape, op: wr_op};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            slot_valid <= '0;
        end else begin
            if (push) begin
                wr_ptr             <= wr_ptr + PTR_W'(1);
                slot_valid[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr             <= rd_ptr + PTR_W'(1);
                slot_valid[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Execution engine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (level != '0) begin
                    pop     = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cycle_cnt == '0) begin
                    commit  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_cmd  <= '0;
            cycle_cnt <= '0;
        end else if (pop) begin
            exec_cmd  <= fifo_mem[rd_ptr];
            cycle_cnt <= CNT_LOAD;
        end else if (state_q == S_EXEC && cycle_cnt != '0) begin
            cycle_cnt <= cycle_cnt - CNT_W'(1);
        end
    end

    assign busy = (level != '0) || (state_q == S_EXEC);

    // Channel control registers
    assign ex_idx = exec_cmd.channel[CH_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                chan_shape[i] <= 2'b01;
                chan_op[i]    <= 5'd0;
                chan_count[i] <= 8'd0;
            end
        end else if (commit) begin
            chan_shape[ex_idx] <= exec_cmd.shape;
            chan_op[ex_idx]    <= exec_cmd.op;
            chan_count[ex_idx] <= chan_count[ex_idx] + 8'd1;
        end
    end

    // Read port: a commit landing on the sampling edge is reflected, while level
    // and queued-entry pending bits show the FIFO as it was before that edge.
    assign rd_idx        = read_channel[CH_W-1:0];
    assign read_in_range = ({1'b0, read_channel} < NUM_CH_L);
    assign commit_hit    = commit && (exec_cmd.channel == read_channel);

    always_comb begin
        pending = (state_q == S_EXEC) && !commit && (exec_cmd.channel == read_channel);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (slot_valid[i] && fifo_mem[i].channel == read_channel) begin
                pending = 1'b1;
            end
        end
    end

    assign view_shape = commit_hit ? exec_cmd.shape : chan_shape[rd_idx];
    assign view_op    = commit_hit ? exec_cmd.op : chan_op[rd_idx];
    assign view_count = commit_hit ? chan_count[rd_idx] + 8'd1 : chan_count[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data <= '0;
        end else if (read) begin
            if (read_in_range) begin
                read_data <= {pending, 7'd0, 8'(level), view_count, 1'b0, view_shape, view_op};
            end else begin
                read_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_multi_shape_processor.sv
// Bench for multi_shape_processor: directed stimulus, a queue-based reference model
// checked every cycle, and hand-computed literal expectations.
module tb_multi_shape_processor;
    localparam int NUM   = 4;
    localparam int DEPTH = 4;
    localparam int OPC   = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        write = 1'b0;
    logic [31:0] write_data = '0;
    logic        read = 1'b0;
    logic [2:0]  read_channel = '0;
    logic [31:0] read_data;
    logic        error;
    logic        busy;

    always #5 clk = ~clk;

    multi_shape_processor #(.NUM_CHANNELS(NUM), .FIFO_DEPTH(DEPTH), .OP_CYCLES(OPC)) dut (
        .clk(clk), .rst_n(rst_n), .write(write), .write_data(write_data),
        .read(read), .read_channel(read_channel), .read_data(read_data),
        .error(error), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: commands as a queue, execution as a scheduled commit edge
    typedef struct { int ch; int shape; int op; } mcmd_t;
    mcmd_t       mq[$];
    mcmd_t       mex, mnew;
    bit          mact, committed, wok;
    int          mcyc, mcommit_at, wch, wsh, wop;
    int          mshape[NUM], mop[NUM], mcnt[NUM];
    logic [31:0] m_read;
    bit          m_err;

    function automatic bit op_allowed(int shape, int op);
        if (shape != 1 && shape != 2) return 1'b0;
        if (op == 0 || op == 1) return 1'b1;
        if (shape == 1 && op == 8) return 1'b1;
        if (shape == 2 && (op == 16 || op == 17)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] resp(int rc);
        logic [31:0] r;
        bit pend;
        if (rc >= NUM) return 32'd0;
        pend = mact && (mex.ch == rc);
        foreach (mq[i]) if (mq[i].ch == rc) pend = 1'b1;
        r = '0;
        r[31]    = pend;
        r[23:16] = 8'(mq.size());
        r[15:8]  = 8'(mcnt[rc]);
        r[6:5]   = 2'(mshape[rc]);
        r[4:0]   = 5'(mop[rc]);
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mact   = 1'b0;
            mcyc   = 0;
            m_read = '0;
            m_err  = 1'b0;
            for (int c = 0; c < NUM; c++) begin
                mshape[c] = 1;
                mop[c]    = 0;
                mcnt[c]   = 0;
            end
        end else begin
            wch   = int'(write_data[26:24]);
            wsh   = int'(write_data[17:16]);
            wop   = int'(write_data[4:0]);
            wok   = op_allowed(wsh, wop) && (wch < NUM) && (mq.size() < DEPTH);
            m_err = write && !wok;
            committed = 1'b0;
            if (mact && mcyc == mcommit_at) begin
                mshape[mex.ch] = mex.shape;
                mop[mex.ch]    = mex.op;
                mcnt[mex.ch]   = (mcnt[mex.ch] + 1) % 256;
                mact      = 1'b0;
                committed = 1'b1;
            end
            if (read) m_read = resp(int'(read_channel));
            if (!mact && !committed && mq.size() > 0) begin
                mex        = mq.pop_front();
                mact       = 1'b1;
                mcommit_at = mcyc + OPC;
            end
            if (write && wok) begin
                mnew.ch = wch; mnew.shape = wsh; mnew.op = wop;
                mq.push_back(mnew);
            end
            mcyc++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_read_data", read_data, m_read);
            chk("model_error", {31'd0, error}, {31'd0, m_err});
            chk("model_busy", {31'd0, busy}, {31'd0, (mq.size() != 0) || mact});
        end
    end

    task automatic drive(input bit w, input logic [31:0] wd, input bit r, input logic [2:0] rc);
        write = w; write_data = wd; read = r; read_channel = rc;
        @(posedge clk); #2;
        write = 1'b0; read = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin @(posedge clk); #2; n++; end
        if (busy) chk("busy_timeout", {31'd0, busy}, 32'd0);
    endtask

    logic [31:0] bad_w [4] = '{32'h0101_0018, 32'h0103_0000, 32'h0101_0010, 32'h0501_0000};
    logic [31:0] ovf_w [6] = '{32'h0002_0011, 32'h0101_0001, 32'h0202_0010,
                               32'h0301_0008, 32'h0001_0000, 32'h0201_0008};
    logic [31:0] wrap_w [3] = '{32'h0001_0000, 32'h0001_0001, 32'h0001_0008};

    initial begin
        int e;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        chk("reset_read_data", read_data, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_error", {31'd0, error}, 32'd0);
        drive(0, '0, 1, 3'd0);
        chk("reset_read_ch0", read_data, 32'h0000_0020);

        // Single legal write and commit timing
        drive(1, 32'h0101_0008, 0, 3'd0);
        chk("legal_no_error", {31'd0, error}, 32'd0);
        chk("busy_after_push", {31'd0, busy}, 32'd1);
        idle(2);
        drive(0, '0, 1, 3'd1);
        chk("read_before_commit", read_data, 32'h8000_0020);
        drive(0, '0, 1, 3'd1);
        chk("read_at_commit", read_data, 32'h0000_0128);
        chk("busy_after_commit", {31'd0, busy}, 32'd0);
        drive(0, '0, 1, 3'd6);
        chk("read_out_of_range", read_data, 32'd0);

        // Illegal writes
        for (int i = 0; i < 4; i++) begin
            drive(1, bad_w[i], 0, 3'd0);
            chk($sformatf("illegal_error_%0d", i), {31'd0, error}, 32'd1);
            chk($sformatf("illegal_busy_%0d", i), {31'd0, busy}, 32'd0);
            idle(1);
            chk($sformatf("illegal_error_drop_%0d", i), {31'd0, error}, 32'd0);
        end
        drive(1, bad_w[0], 0, 3'd0);
        drive(1, bad_w[1], 0, 3'd0);
        chk("consecutive_reject_high", {31'd0, error}, 32'd1);
        idle(1);
        drive(0, '0, 1, 3'd1);
        chk("illegal_no_change", read_data, 32'h0000_0128);

        // Overflow: six back-to-back legal writes, the sixth finds the FIFO full
        for (int i = 0; i < 6; i++) begin
            drive(1, ovf_w[i], 1, 3'(i % NUM));
            chk($sformatf("ovf_error_%0d", i), {31'd0, error}, (i == 5) ? 32'd1 : 32'd0);
        end
        e = 5;
        while (busy && e < 60) begin @(posedge clk); #2; e++; end
        chk("ovf_busy_fall_edge", 32'(e), 32'd20);
        drive(0, '0, 1, 3'd0);
        chk("ovf_ch0", read_data, 32'h0000_0220);
        drive(0, '0, 1, 3'd2);
        chk("ovf_ch2", read_data, 32'h0000_0150);

        // Reset in the middle of execution with two commands queued
        drive(1, 32'h0101_0001, 0, 3'd0);
        drive(1, 32'h0202_0011, 0, 3'd0);
        drive(1, 32'h0301_0000, 0, 3'd0);
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_read_data", read_data, 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(10);
        for (int c = 0; c < NUM; c++) begin
            drive(0, '0, 1, 3'(c));
            chk($sformatf("post_reset_ch%0d", c), read_data, 32'h0000_0020);
        end

        // Commit count wrap on channel 0
        for (int i = 0; i < 256; i++) begin
            drive(1, (i == 255) ? 32'h0002_0011 : wrap_w[i % 3], 0, 3'd0);
            wait_idle(20);
            if (i == 254) begin
                drive(0, '0, 1, 3'd0);
                chk("count_255", read_data, 32'h0000_FF28);
            end
        end
        drive(0, '0, 1, 3'd0);
        chk("count_wrap", read_data, 32'h0000_0051);

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end
endmodule
